// File: rtl/lpddr4_ca_pkg.sv
// LPDDR4 CA decoder shared types.
// Opcodes, command/error encodings, decoded-command record.
package lpddr4_ca_pkg;

  localparam logic [1:0] OP_ACT1 = 2'b01;
  localparam logic [1:0] OP_ACT2 = 2'b11;
  localparam logic [4:0] OP_PRE  = 5'b10000;
  localparam logic [4:0] OP_REF  = 5'b01000;
  localparam logic [4:0] OP_RD1  = 5'b00010;
  localparam logic [4:0] OP_WR1  = 5'b00100;
  localparam logic [4:0] OP_MWR1 = 5'b01100;
  localparam logic [4:0] OP_CAS2 = 5'b10010;

  typedef enum logic [2:0] {
    CMD_ACT = 3'd0,
    CMD_RD  = 3'd1,
    CMD_WR  = 3'd2,
    CMD_MWR = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_type_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_UNSUP   = 3'd1,
    ERR_FRAME   = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_SEQ     = 3'd4,
    ERR_ACT_OPN = 3'd5,
    ERR_BNK_CLS = 3'd6,
    ERR_REF_OPN = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_F1B,
    S_WAIT2,
    S_F2B
  } state_e;

  typedef struct packed {
    cmd_type_e   ctype;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  flag;
  } cmd_t;

endpackage

// File: rtl/lpddr4_ca_if.sv
// Decoded-command output channel.
// valid/ready handshake plus the head command fields.
interface lpddr4_ca_if;
  import lpddr4_ca_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  cmd_type_e   cmd_type;
  logic [2:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [1:0]  cmd_flag;

  modport master (
    output cmd_valid, cmd_type, cmd_bank,
    output cmd_row, cmd_col, cmd_flag,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_bank,
    input  cmd_row, cmd_col, cmd_flag,
    output cmd_ready
  );
endinterface

// File: rtl/lpddr4_cmd_fifo.sv
// Synchronous FIFO, drop-on-full with sticky overflow.
// Head reads as zero while empty.
module lpddr4_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic             full, do_pop, do_push;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rp[AW-1:0]];

  // Pointer and sticky overflow update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/lpddr4_ca_decoder.sv
// LPDDR4 CA receiver: reassembles multi-tick commands into a FIFO.
// Optional bank tracking under LPDDR4_BANK_TRACK_EN.
module lpddr4_ca_decoder
  import lpddr4_ca_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_GAP    = 4,
  parameter int NUM_BANKS  = 8
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs,
  input  logic [5:0]  ca,
  lpddr4_ca_if.master cmd,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        overflow
);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [2:0] BMASK = 3'(NUM_BANKS - 1);

  state_e      state;
  cmd_t        cur, pkt, head;
  logic [GW-1:0] gap;
  err_code_e   ecode, bank_code;
  logic        bank_err, done, empty;
  logic [$bits(cmd_t)-1:0] fifo_dout;
  logic        is_act1, is_act2, is_pre, is_ref;
  logic        is_rd, is_wr, is_mwr, is_cas2, is_pr;

  assign is_act1 = (ca[1:0] == OP_ACT1);
  assign is_act2 = (ca[1:0] == OP_ACT2);
  assign is_pre  = (ca[4:0] == OP_PRE);
  assign is_ref  = (ca[4:0] == OP_REF);
  assign is_rd   = (ca[4:0] == OP_RD1);
  assign is_wr   = (ca[4:0] == OP_WR1);
  assign is_mwr  = (ca[4:0] == OP_MWR1);
  assign is_cas2 = (ca[4:0] == OP_CAS2);
  assign is_pr   = (cur.ctype == CMD_PRE) ||
                   (cur.ctype == CMD_REF);

  assign done = cke && !cs &&
                ((state == S_F2B) ||
                 (state == S_F1B && is_pr));

  // Final tick B fields merged into the captured command.
  always_comb begin
    pkt = cur;
    if (state == S_F1B)
      pkt.bank = ca[2:0] & BMASK;
    else if (cur.ctype == CMD_ACT)
      pkt.row[5:0] = ca;
    else
      pkt.col[7:2] = ca;
  end

  // Command reassembly FSM with registered error pulse.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cur   <= '0;
      gap   <= '0;
      err   <= 1'b0;
      ecode <= ERR_NONE;
    end else begin
      err   <= 1'b0;
      ecode <= ERR_NONE;
      if (done && bank_err) begin
        err   <= 1'b1;
        ecode <= bank_code;
      end
      if (cke) begin
        unique case (state)
          S_IDLE: if (cs) begin
            cur <= '0;
            unique case (1'b1)
              is_act1: begin
                cur.ctype      <= CMD_ACT;
                cur.row[15:12] <= ca[5:2];
                state          <= S_F1B;
              end
              is_pre, is_ref: begin
                cur.ctype   <= is_pre ? CMD_PRE : CMD_REF;
                cur.flag[0] <= ca[5];
                state       <= S_F1B;
              end
              is_rd, is_wr, is_mwr: begin
                cur.ctype   <= is_rd ? CMD_RD :
                               is_wr ? CMD_WR : CMD_MWR;
                cur.flag[1] <= ca[5];
                state       <= S_F1B;
              end
              is_act2, is_cas2: begin
                err   <= 1'b1;
                ecode <= ERR_SEQ;
              end
              default: begin
                err   <= 1'b1;
                ecode <= ERR_UNSUP;
              end
            endcase
          end
          S_F1B: begin
            if (cs) begin
              err   <= 1'b1;
              ecode <= ERR_FRAME;
              state <= S_IDLE;
            end else if (is_pr) begin
              state <= S_IDLE;
            end else begin
              cur.bank <= ca[2:0] & BMASK;
              if (cur.ctype == CMD_ACT) begin
                cur.row[11:10] <= ca[5:4];
              end else begin
                cur.col[9]  <= ca[4];
                cur.flag[0] <= ca[5];
              end
              gap   <= '0;
              state <= S_WAIT2;
            end
          end
          S_WAIT2: begin
            if (cs) begin
              if (cur.ctype == CMD_ACT ? is_act2 : is_cas2) begin
                if (cur.ctype == CMD_ACT)
                  cur.row[9:6] <= ca[5:2];
                else
                  cur.col[8] <= ca[5];
                state <= S_F2B;
              end else begin
                err   <= 1'b1;
                ecode <= ERR_SEQ;
                state <= S_IDLE;
              end
            end else if (gap == GW'(MAX_GAP)) begin
              err   <= 1'b1;
              ecode <= ERR_TIMEOUT;
              state <= S_IDLE;
            end else begin
              gap <= gap + 1'b1;
            end
          end
          S_F2B: begin
            if (cs) begin
              err   <= 1'b1;
              ecode <= ERR_FRAME;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LPDDR4_BANK_TRACK_EN
  logic [NUM_BANKS-1:0] open_q;
  logic rwm;

  assign rwm = (pkt.ctype == CMD_RD) ||
               (pkt.ctype == CMD_WR) ||
               (pkt.ctype == CMD_MWR);

  // Bank-state violations seen by the completing command.
  always_comb begin
    bank_err  = 1'b0;
    bank_code = ERR_NONE;
    if (pkt.ctype == CMD_ACT && open_q[pkt.bank]) begin
      bank_err  = 1'b1;
      bank_code = ERR_ACT_OPN;
    end else if (rwm && !open_q[pkt.bank]) begin
      bank_err  = 1'b1;
      bank_code = ERR_BNK_CLS;
    end else if (pkt.ctype == CMD_REF && pkt.flag[0] &&
                 |open_q) begin
      bank_err  = 1'b1;
      bank_code = ERR_REF_OPN;
    end
  end

  // Open/closed table updated at command completion.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
    end else if (done) begin
      if (pkt.ctype == CMD_ACT)
        open_q[pkt.bank] <= 1'b1;
      else if (pkt.ctype == CMD_PRE && pkt.flag[0])
        open_q <= '0;
      else if (pkt.ctype == CMD_PRE)
        open_q[pkt.bank] <= 1'b0;
      else if (rwm && pkt.flag[0])
        open_q[pkt.bank] <= 1'b0;
    end
  end
`else
  assign bank_err  = 1'b0;
  assign bank_code = ERR_NONE;
`endif

  lpddr4_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk      (ck),
    .rst_n    (rst_n),
    .push     (done),
    .din      (pkt),
    .pop      (cmd.cmd_ready),
    .dout     (fifo_dout),
    .empty    (empty),
    .overflow (overflow)
  );

  assign head          = cmd_t'(fifo_dout);
  assign cmd.cmd_valid = !empty;
  assign cmd.cmd_type  = head.ctype;
  assign cmd.cmd_bank  = head.bank;
  assign cmd.cmd_row   = head.row;
  assign cmd.cmd_col   = head.col;
  assign cmd.cmd_flag  = head.flag;
  assign err_code      = ecode;
endmodule

// File: tb/tb_lpddr4_ca_decoder.sv
// Scoreboard bench for lpddr4_ca_decoder.
// Commands are issued by field; a queue model predicts FIFO output.
module tb_lpddr4_ca_decoder;
  import lpddr4_ca_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       cke = 1'b1;
  logic       cs = 1'b0;
  logic [5:0] ca = '0;
  logic       err, overflow;
  logic [2:0] err_code;

  lpddr4_ca_if cmd();

  lpddr4_ca_decoder #(
    .FIFO_DEPTH (DEPTH),
    .MAX_GAP    (GAP),
    .NUM_BANKS  (8)
  ) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .cke      (cke),
    .cs       (cs),
    .ca       (ca),
    .cmd      (cmd),
    .err      (err),
    .err_code (err_code),
    .overflow (overflow)
  );

  always #5 ck = ~ck;

  int   n_chk = 0;
  int   n_pass = 0;
  cmd_t q[$];
  bit   pend_push = 0;
  cmd_t pend_cmd = '0;
  int   pend_err = 0;
  bit   exp_err = 0;
  logic [2:0] exp_code = '0;
  bit   exp_ovf = 0;
  int   rmode = 1;
  bit   bopen[8];

  function automatic void check(string nm,
                                logic [63:0] got,
                                logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, got, exp, $time);
  endfunction

  // Bank table in plain arrays; returns expected err code.
  function automatic int bank_upd(cmd_t e);
    int code = 0;
`ifdef LPDDR4_BANK_TRACK_EN
    bit any = 0;
    foreach (bopen[i]) any |= bopen[i];
    case (e.ctype)
      CMD_ACT: begin
        if (bopen[e.bank]) code = 5;
        bopen[e.bank] = 1;
      end
      CMD_RD, CMD_WR, CMD_MWR: begin
        if (!bopen[e.bank]) code = 6;
        if (e.flag[0]) bopen[e.bank] = 0;
      end
      CMD_PRE: begin
        if (e.flag[0]) foreach (bopen[i]) bopen[i] = 0;
        else bopen[e.bank] = 0;
      end
      CMD_REF: if (e.flag[0] && any) code = 7;
      default: ;
    endcase
`endif
    return code;
  endfunction

  task automatic tick(input logic c, input logic [5:0] a,
                      input bit p = 0, input cmd_t pc = '0,
                      input int e = 0, input logic k = 1);
    @(negedge ck);
    cs = c; ca = a; cke = k;
    pend_push = p; pend_cmd = pc; pend_err = e;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 6'($urandom));
  endtask

  // Issue one command by fields; g = DES cycles before fragment 2.
  task automatic issue(input cmd_type_e k, input logic [2:0] b,
                       input logic [15:0] r, input logic [9:0] c,
                       input logic ap, input logic bl,
                       input logic ab, input int g);
    cmd_t e;
    logic [2:0] x;
    e = '0; e.ctype = k; e.bank = b;
    x = 3'($urandom);
    if (k == CMD_PRE || k == CMD_REF) begin
      e.flag = {1'b0, ab};
      tick(1, {ab, (k == CMD_PRE) ? OP_PRE : OP_REF});
      tick(0, {x, b}, 1, e, bank_upd(e));
      return;
    end
    if (k == CMD_ACT) begin
      e.row = r;
      tick(1, {r[15:12], OP_ACT1});
      tick(0, {r[11:10], x[0], b});
    end else begin
      e.col = {c[9:2], 2'b00};
      e.flag = {bl, ap};
      tick(1, {bl, (k == CMD_RD) ? OP_RD1 :
                   (k == CMD_WR) ? OP_WR1 : OP_MWR1});
      tick(0, {ap, c[9], x[0], b});
    end
    for (int i = 0; i < g; i++) begin
      if (i == GAP) begin
        tick(0, 6'($urandom), 0, '0, 3);
        return;
      end
      tick(0, 6'($urandom));
    end
    if (k == CMD_ACT) begin
      tick(1, {r[9:6], OP_ACT2});
      tick(0, r[5:0], 1, e, bank_upd(e));
    end else begin
      tick(1, {c[8], OP_CAS2});
      tick(0, c[7:2], 1, e, bank_upd(e));
    end
  endtask

  // Consumer ready pattern.
  initial begin
    cmd.cmd_ready = 1'b1;
    forever begin
      @(negedge ck);
      cmd.cmd_ready = (rmode == 2) ?
        ($urandom_range(0, 3) != 0) : (rmode == 1);
    end
  end

  // Reference model: FIFO occupancy, drops, error pulses.
  initial forever begin
    @(posedge ck);
    if (!rst_n) begin
      q.delete(); exp_ovf = 0; exp_err = 0; exp_code = '0;
    end else begin
      if (q.size() != 0 && cmd.cmd_ready) void'(q.pop_front());
      exp_err  = (pend_err != 0);
      exp_code = 3'(pend_err);
      if (pend_push) begin
        if (q.size() == DEPTH) exp_ovf = 1;
        else q.push_back(pend_cmd);
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard.
  initial forever begin
    @(posedge ck);
    #2;
    if (rst_n) begin
      check("valid", cmd.cmd_valid, q.size() != 0);
      if (q.size() != 0)
        check("head", {cmd.cmd_type, cmd.cmd_bank, cmd.cmd_row,
                       cmd.cmd_col, cmd.cmd_flag}, q[0]);
      if (err || exp_err) begin
        check("err", err, exp_err);
        check("err_code", err_code, exp_code);
      end
      check("overflow", overflow, exp_ovf);
    end
  end

  initial begin
    cmd_t e;
    rmode = 1;
    repeat (2) @(negedge ck);
    check("rst_valid", cmd.cmd_valid, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fields", {cmd.cmd_type, cmd.cmd_bank, cmd.cmd_row,
                         cmd.cmd_col, cmd.cmd_flag}, 0);
    rst_n = 1;
    idle(2);

    issue(CMD_ACT, 3'd5, 16'hA3C7, '0, 0, 0, 0, 0);
    @(posedge ck); #2;
    check("act_valid", cmd.cmd_valid, 1);
    check("act_type", cmd.cmd_type, 0);
    check("act_bank", cmd.cmd_bank, 5);
    check("act_row", cmd.cmd_row, 16'hA3C7);
    idle(2);

    issue(CMD_RD, 3'd2, '0, 10'h254, 1, 1, 0, 2);
    @(posedge ck); #2;
    check("rd_type", cmd.cmd_type, 1);
    check("rd_col", cmd.cmd_col, 10'h254);
    check("rd_flag", cmd.cmd_flag, 2'b11);
    idle(2);

    issue(CMD_WR, 3'd1, '0, 10'h3FC, 0, 0, 0, 5);
    @(posedge ck); #2;
    check("to_err", err, 1);
    check("to_code", err_code, 3);
    idle(2);
    check("to_pulse", err, 0);

    tick(1, {4'hA, OP_ACT1});
    tick(1, {1'b0, OP_PRE}, 0, '0, 2);
    idle(2);
    tick(1, 6'b000110, 0, '0, 1);
    idle(2);
    tick(1, {1'b0, OP_RD1});
    tick(0, 6'd1);
    tick(1, {1'b0, OP_PRE}, 0, '0, 4);
    idle(2);

    e = '0; e.ctype = CMD_ACT; e.bank = 3'd6;
    e.row = {4'h3, 2'b10, 4'h5, 6'h2A};
    tick(1, {4'h3, OP_ACT1});
    tick(0, {2'b10, 1'b0, 3'd6});
    repeat (3) tick(1, 6'($urandom), 0, '0, 0, 0);
    tick(1, {4'h5, OP_ACT2});
    tick(0, 6'h2A, 1, e, bank_upd(e));
    idle(3);

    rmode = 0;
    idle(2);
    for (int i = 0; i < 5; i++)
      issue(CMD_PRE, 3'(i), '0, '0, 0, 0, 0, 0);
    idle(3);
    check("ovf_set", overflow, 1);
    check("ovf_valid", cmd.cmd_valid, 1);
    rmode = 1;
    idle(8);
    check("ovf_sticky", overflow, 1);

    tick(1, {4'h7, OP_ACT1});
    tick(0, 6'd4);
    tick(0, 6'd0);
    rst_n = 0;
    foreach (bopen[i]) bopen[i] = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    check("rstm_valid", cmd.cmd_valid, 0);
    check("rstm_err", err, 0);
    check("rstm_ovf", overflow, 0);
    issue(CMD_PRE, 3'd4, '0, '0, 0, 0, 1, 0);
    @(posedge ck); #2;
    check("rstm_pre", cmd.cmd_type, 4);
    check("rstm_ab", cmd.cmd_flag, 2'b01);
    idle(2);

    issue(CMD_RD, 3'd3, '0, 10'h0A8, 0, 0, 0, 0);
    @(posedge ck); #2;
    check("bt_rd", cmd.cmd_bank, 3);
`ifdef LPDDR4_BANK_TRACK_EN
    check("bt_err", err_code, 6);
`endif
    idle(2);

    rmode = 2;
    for (int n = 0; n < 200; n++) begin
      issue(cmd_type_e'($urandom_range(0, 5)), 3'($urandom),
            16'($urandom), 10'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end
    rmode = 1;
    idle(12);
    check("drained", cmd.cmd_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lpddr4_ca_decoder.md
Name: lpddr4_ca_decoder

Overview:
- DRAM-side receiver for the LPDDR4 command/address bus driven by the controller (ck, cs, cke, ca).
- Samples CS/CA on rising ck and reassembles the multi-tick LPDDR4 commands: ACT-1+ACT-2, RD/WR/MWR-1+CAS-2, PRE, REF.
- Emits one decoded command per legal sequence into a small FIFO with valid/ready handshake.
- Used in the board-bring-up memory responder model and in CA-capture debug logic.

Parameters:
- FIFO_DEPTH, 4, decoded-command FIFO entries; power of 2, minimum 2.
- MAX_GAP, 4, maximum DES cycles allowed between the first and second fragment of a two-fragment command.
- NUM_BANKS, 8, number of banks tracked; bank field width is 3.

Ports:
- ck  input  1  memory clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cke  input  1  clock enable; 0 freezes decode.
- cs  input  1  chip select; 1 marks tick A of a fragment.
- ca  input  6  command/address bus.
- cmd_valid  output  1  FIFO head is valid.
- cmd_ready  input  1  consumer accepts the head.
- cmd_type  output  3  ACT=0, RD=1, WR=2, MWR=3, PRE=4, REF=5.
- cmd_bank  output  3  bank address.
- cmd_row  output  16  row address (ACT only, else 0).
- cmd_col  output  10  column; C[1:0] are always 0.
- cmd_flag  output  2  [0]=AP for RD/WR/MWR, AB for PRE/REF; [1]=BL from RD/WR tick A.
- err  output  1  one-cycle pulse on a protocol violation.
- err_code  output  3  cause, valid while err=1.
- overflow  output  1  sticky; set when a decode completes while the FIFO is full. Cleared only by reset.

Behaviour:
- Reset: FSM=IDLE, FIFO empty. cmd_valid, err, err_code, overflow all 0. cmd_* fields 0.
- Tick A (cs=1), opcode is ca[4:0]:
  - 00001 ACT-1 (ca1=0, ca0=1); 00011 ACT-2.
  - 10000 PRE; 01000 REF.
  - 00010 RD-1; 00100 WR-1; 01100 MWR-1.
  - 10010 CAS-2.
  - Any other opcode: err code 1 (unsupported), FSM returns to IDLE.
- Every tick A is followed by tick B on the next enabled cycle with cs=0.
- Field mapping:
  - ACT-1: A ca[5:2]=R[15:12]; B ca[2:0]=BA, ca[5:4]=R[11:10].
  - ACT-2: A ca[5:2]=R[9:6]; B ca[5:0]=R[5:0].
  - RD/WR/MWR-1: A ca5=BL; B ca[2:0]=BA, ca4=C9, ca5=AP.
  - CAS-2: A ca5=C8; B ca[5:0]=C[7:2].
  - PRE/REF: A ca5=AB; B ca[2:0]=BA.
- FSM states and transitions:
  - IDLE --tickA--> F1B.
  - F1B: if cs=1, err code 2 (framing) and go to IDLE. Otherwise capture fields; PRE/REF complete and go to IDLE; ACT/RD/WR/MWR go to WAIT2.
  - WAIT2: cs=0 increments the gap counter; gap > MAX_GAP gives err code 3 (timeout) and IDLE.
  - WAIT2 with cs=1: expected opcode (ACT-2 after ACT-1, CAS-2 after RD/WR/MWR-1) goes to F2B. Any other opcode gives err code 4 (sequence) and IDLE; that tick is not re-decoded.
  - F2B: cs=1 gives err code 2 and IDLE; otherwise the command completes and FSM goes to IDLE.
- Completion: entry written at the ck edge sampling the final tick B. cmd_valid is high from the following cycle (1-cycle latency).
- FIFO:
  - Pop when cmd_valid && cmd_ready.
  - Simultaneous push and pop when full is legal; no overflow.
  - Push when full with no pop: entry dropped, overflow set.
  - Head fields are stable while cmd_valid=1 and cmd_ready=0.
- cke=0: FSM, gap counter and bank table hold; CA is ignored. The FIFO still pops.
- Reset asserted mid-command: partial state discarded immediately; no command or err produced.
- err is a single-cycle pulse per violation, never stretched.

Optional Feature:
- Macro LPDDR4_BANK_TRACK_EN.
- Defined: a per-bank open/closed table is maintained at command completion.
  - ACT to an open bank: err code 5.
  - RD/WR/MWR to a closed bank: err code 6.
  - The command is still pushed in both cases.
  - ACT opens the bank. PRE closes it; with AB=1, all banks close. RD/WR/MWR with AP=1 closes the bank.
  - REF with AB=1 while any bank is open: err code 7.
- Undefined: no table exists and codes 5-7 never occur.

Decomposition:
- Package lpddr4_ca_pkg holds:
  - opcode localparams;
  - cmd_type enum;
  - err_code enum;
  - a packed decoded-command struct (type, bank, row, col, flag = 34 bits).
- One sub-module, lpddr4_cmd_fifo: a parameterised synchronous FIFO with async active-low reset, full/empty flags, and a drop-on-full overflow flag.

Test Plan:
- ACT-1 (R[15:12]=0xA) then ACT-2, back-to-back, bank 5, row 0xA3C7 -> one cycle after the last tick: cmd_valid=1, type=0, bank=5, row=0xA3C7.
- RD-1 (BL=1, bank 2, AP=1, C9=1), 2 DES cycles, then CAS-2 (C8=0, C[7:2]=0x15) -> type=1, col=0x254, flag=2'b11.
- WR-1 followed by 5 DES cycles with MAX_GAP=4 -> err=1 for one cycle, code 3; no FIFO push.
- cmd_ready=0, 5 PRE commands issued -> 4 entries held, overflow=1. Then cmd_ready=1 -> entries pop in order; overflow stays 1.
- rst_n dropped during WAIT2 of an ACT -> cmd_valid=0, no err; the next PRE decodes normally.
- With LPDDR4_BANK_TRACK_EN: RD to bank 3 without a prior ACT -> err code 6, and the command still appears at the FIFO output.
